// File: rtl/gfx_mem_arbiter.sv
// gfx_mem_arbiter: four-requester round-robin arbiter for a shared
// graphics memory read port (0=spcon, 1=bg0, 2=bg1, 3=ov).
// One outstanding read at a time: IDLE -> ISSUE -> RESP -> IDLE.
// Optional feature macro: GFX_ARB_TIMEOUT_EN aborts a read that stays in
// ISSUE for TIMEOUT cycles and raises a sticky TIMEOUT_ERR.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; arbitrate among REQ_RVALID starting at ptr
// ISSUE | MEM_RVALID high, MEM_ADDRESS held; waiting for MEM_RREADY
// RESP  | one-cycle REQ_RREADY pulse to GRANT; REQ_RVALID not sampled

module gfx_mem_arbiter #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 16,
    parameter int TIMEOUT      = 63
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [4*ADDRESS_BITS-1:0] REQ_ADDRESS,
    input  logic [3:0]                REQ_RVALID,
    output logic [3:0]                REQ_RREADY,
    output logic [BITS-1:0]           REQ_DATA,
    output logic [ADDRESS_BITS-1:0]   MEM_ADDRESS,
    output logic                      MEM_RVALID,
    input  logic                      MEM_RREADY,
    input  logic [BITS-1:0]           MEM_DATA,
    output logic [1:0]                GRANT,
    output logic                      TIMEOUT_ERR
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]              state;
    logic [1:0]              ptr;
    logic [1:0]              winner;
    logic [ADDRESS_BITS-1:0] win_addr;
    logic                    tmo_hit;

    // Round-robin pick: first requester at or after ptr, wrapping 3 -> 0.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && REQ_RVALID[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Address of the winning requester.
    always_comb begin
        win_addr = '0;
        for (int i = 0; i < 4; i++) begin
            if (winner == 2'(i)) begin
                win_addr = REQ_ADDRESS[i*ADDRESS_BITS +: ADDRESS_BITS];
            end
        end
    end

`ifdef GFX_ARB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    logic [TCNT_W-1:0] tcnt;
    logic              terr;

    // The abort fires on the TIMEOUT-th ISSUE cycle that sees no MEM_RREADY.
    assign tmo_hit = (state == ISSUE) && !MEM_RREADY &&
                     (tcnt == TCNT_W'(TIMEOUT - 1));

    // ISSUE-cycle counter, cleared on entry; sticky error until reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt <= '0;
            terr <= 1'b0;
        end else begin
            if (state == IDLE && |REQ_RVALID) begin
                tcnt <= '0;
            end else if (state == ISSUE) begin
                tcnt <= tcnt + TCNT_W'(1);
            end
            if (tmo_hit) begin
                terr <= 1'b1;
            end
        end
    end

    assign TIMEOUT_ERR = terr;
`else
    assign tmo_hit     = 1'b0;
    assign TIMEOUT_ERR = 1'b0;
`endif

    // Main transaction FSM; grant, address and response data are registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            GRANT       <= 2'd0;
            MEM_ADDRESS <= '0;
            REQ_DATA    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|REQ_RVALID) begin
                        GRANT       <= winner;
                        MEM_ADDRESS <= win_addr;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (MEM_RREADY) begin
                        REQ_DATA <= MEM_DATA;
                        state    <= RESP;
                    end else if (tmo_hit) begin
                        REQ_DATA <= '0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    ptr   <= GRANT + 2'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MEM_RVALID = (state == ISSUE);

    // One-hot data-valid pulse to the granted requester during RESP.
    always_comb begin
        REQ_RREADY = 4'b0000;
        if (state == RESP) begin
            REQ_RREADY[GRANT] = 1'b1;
        end
    end

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Bench for gfx_mem_arbiter: cycle-level vector table plus hand-written
// reset-abort and timeout / no-timeout sequences.
module tb_gfx_mem_arbiter;

    localparam int TMO = 63;

    logic        CLK = 1'b0;
    logic        RST;
    logic [63:0] REQ_ADDRESS;
    logic [3:0]  REQ_RVALID;
    logic [3:0]  REQ_RREADY;
    logic [15:0] REQ_DATA;
    logic [15:0] MEM_ADDRESS;
    logic        MEM_RVALID;
    logic        MEM_RREADY;
    logic [15:0] MEM_DATA;
    logic [1:0]  GRANT;
    logic        TIMEOUT_ERR;

    int total = 0;
    int bad   = 0;

    logic [15:0] adr [4];

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic        mr;
        logic [15:0] md;
        logic        e_mv;
        logic [1:0]  e_gr;
        logic [3:0]  e_rr;
        logic [15:0] e_dat;
        logic [15:0] e_addr;
    } vec_t;

    vec_t tbl[$];

    gfx_mem_arbiter #(.BITS(16), .ADDRESS_BITS(16), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_ADDRESS(REQ_ADDRESS), .REQ_RVALID(REQ_RVALID),
        .REQ_RREADY(REQ_RREADY), .REQ_DATA(REQ_DATA),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_RVALID(MEM_RVALID),
        .MEM_RREADY(MEM_RREADY), .MEM_DATA(MEM_DATA),
        .GRANT(GRANT), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic rst, logic [3:0] rv, logic mr, logic [15:0] md,
                                logic mv, logic [1:0] gr, logic [3:0] rr,
                                logic [15:0] dat, logic [15:0] addr);
        vec_t v;
        v.rst = rst; v.rv = rv; v.mr = mr; v.md = md;
        v.e_mv = mv; v.e_gr = gr; v.e_rr = rr; v.e_dat = dat; v.e_addr = addr;
        return v;
    endfunction

    initial begin
        logic [15:0] dprev;
        logic [1:0]  g;
        int          cnt;
        int          stuck;

        adr[0] = 16'hA000; adr[1] = 16'h1234; adr[2] = 16'hB222; adr[3] = 16'hC333;
        REQ_ADDRESS = {adr[3], adr[2], adr[1], adr[0]};
        RST = 1'b1; REQ_RVALID = 4'b0; MEM_RREADY = 1'b0; MEM_DATA = 16'h0;

        // rst, rv, mr, md | mem_rvalid, grant, rready, data, mem_address
        tbl.push_back(mk(1, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000));
        // single request from bg0, memory answers on second ISSUE cycle
        tbl.push_back(mk(0, 4'h2, 0, 16'h0000, 1, 1, 4'h0, 16'h0000, 16'h1234));
        tbl.push_back(mk(0, 4'h2, 0, 16'h0000, 1, 1, 4'h0, 16'h0000, 16'h1234));
        tbl.push_back(mk(0, 4'h2, 1, 16'hBEEF, 0, 1, 4'h2, 16'hBEEF, 16'h1234));
        // request still high in RESP: not re-granted
        tbl.push_back(mk(0, 4'h2, 0, 16'h0000, 0, 1, 4'h0, 16'hBEEF, 16'h1234));
        // MEM_RREADY in IDLE is ignored
        tbl.push_back(mk(0, 4'h0, 1, 16'hDEAD, 0, 1, 4'h0, 16'hBEEF, 16'h1234));
        // 0 and 3 together with ptr=2: 3 first, then 0
        tbl.push_back(mk(0, 4'h9, 0, 16'h0000, 1, 3, 4'h0, 16'hBEEF, 16'hC333));
        tbl.push_back(mk(0, 4'h9, 1, 16'h3333, 0, 3, 4'h8, 16'h3333, 16'hC333));
        tbl.push_back(mk(0, 4'h9, 0, 16'h0000, 0, 3, 4'h0, 16'h3333, 16'hC333));
        tbl.push_back(mk(0, 4'h1, 0, 16'h0000, 1, 0, 4'h0, 16'h3333, 16'hA000));
        // requester drops mid-transaction: still completes
        tbl.push_back(mk(0, 4'h0, 1, 16'h0A0A, 0, 0, 4'h1, 16'h0A0A, 16'hA000));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0A0A, 16'hA000));
        // reset with requests pending, then all four requesting continuously
        tbl.push_back(mk(1, 4'hF, 1, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000));
        dprev = 16'h0000;
        for (int t = 0; t < 6; t++) begin
            g = 2'(t % 4);
            tbl.push_back(mk(0, 4'hF, 1, 16'hEEEE, 1, g, 4'h0, dprev, adr[g]));
            dprev = 16'hD000 + 16'(t);
            tbl.push_back(mk(0, 4'hF, 1, dprev, 0, g, 4'h1 << g, dprev, adr[g]));
            if (t < 5)
                tbl.push_back(mk(0, 4'hF, 1, 16'hEEEE, 0, g, 4'h0, dprev, adr[g]));
        end

        for (int k = 0; k < tbl.size(); k++) begin
            RST = tbl[k].rst; REQ_RVALID = tbl[k].rv;
            MEM_RREADY = tbl[k].mr; MEM_DATA = tbl[k].md;
            step();
            chk($sformatf("v%0d mem_rvalid", k), 32'(MEM_RVALID), 32'(tbl[k].e_mv));
            chk($sformatf("v%0d grant", k), 32'(GRANT), 32'(tbl[k].e_gr));
            chk($sformatf("v%0d req_rready", k), 32'(REQ_RREADY), 32'(tbl[k].e_rr));
            chk($sformatf("v%0d req_data", k), 32'(REQ_DATA), 32'(tbl[k].e_dat));
            chk($sformatf("v%0d mem_address", k), 32'(MEM_ADDRESS), 32'(tbl[k].e_addr));
            chk($sformatf("v%0d timeout_err", k), 32'(TIMEOUT_ERR), 32'd0);
        end

        // reset during the second ISSUE cycle aborts the transaction
        RST = 1'b0; REQ_RVALID = 4'h0; MEM_RREADY = 1'b0; step();
        RST = 1'b1; step();
        RST = 1'b0; REQ_RVALID = 4'h2; step();
        chk("abort first issue", 32'(MEM_RVALID), 32'd1);
        step();
        chk("abort second issue", 32'(MEM_RVALID), 32'd1);
        RST = 1'b1; step();
        chk("abort mem_rvalid", 32'(MEM_RVALID), 32'd0);
        chk("abort req_rready", 32'(REQ_RREADY), 32'd0);
        chk("abort grant", 32'(GRANT), 32'd0);
        chk("abort mem_address", 32'(MEM_ADDRESS), 32'd0);
        RST = 1'b0; REQ_RVALID = 4'h0; step();
        chk("abort no pulse", 32'(REQ_RREADY), 32'd0);
        REQ_RVALID = 4'h4; step();
        chk("post-abort grant", 32'(GRANT), 32'd2);
        chk("post-abort address", 32'(MEM_ADDRESS), 32'(16'hB222));
        chk("post-abort mem_rvalid", 32'(MEM_RVALID), 32'd1);
        MEM_RREADY = 1'b1; MEM_DATA = 16'h4242; step();
        chk("post-abort rready", 32'(REQ_RREADY), 32'(4'h4));
        chk("post-abort data", 32'(REQ_DATA), 32'(16'h4242));
        REQ_RVALID = 4'h0; MEM_RREADY = 1'b0; step();
        chk("post-abort idle", 32'(REQ_RREADY), 32'd0);

        // memory never answers (ptr=3 here, so requester 0 wins)
        REQ_RVALID = 4'h1; step();
        chk("stall grant", 32'(GRANT), 32'd0);
        REQ_RVALID = 4'h0;
`ifdef GFX_ARB_TIMEOUT_EN
        cnt = 0;
        while (MEM_RVALID && cnt < 300) begin
            cnt++;
            step();
        end
        chk("timeout issue cycles", 32'(cnt), 32'(TMO));
        chk("timeout mem_rvalid", 32'(MEM_RVALID), 32'd0);
        chk("timeout rready", 32'(REQ_RREADY), 32'(4'h1));
        chk("timeout data", 32'(REQ_DATA), 32'd0);
        chk("timeout err", 32'(TIMEOUT_ERR), 32'd1);
        for (int i = 0; i < 3; i++) step();
        chk("timeout err sticky", 32'(TIMEOUT_ERR), 32'd1);
        chk("timeout back idle", 32'(REQ_RREADY), 32'd0);
        RST = 1'b1; step();
        chk("timeout err reset", 32'(TIMEOUT_ERR), 32'd0);
        RST = 1'b0;
`else
        stuck = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!MEM_RVALID || REQ_RREADY != 4'h0) stuck++;
        end
        chk("no-timeout hold", 32'(stuck), 32'd0);
        chk("no-timeout mem_rvalid", 32'(MEM_RVALID), 32'd1);
        chk("no-timeout err", 32'(TIMEOUT_ERR), 32'd0);
        RST = 1'b1; step();
        chk("no-timeout reset", 32'(MEM_RVALID), 32'd0);
        RST = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
